// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor rounding,
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_divisor(input int clock, input int baudrate);
        return (clock + baudrate / 2) / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIVISOR-1 and pulses tick on the last count.
// HALF_START preloads half a period on clear so a receiver can sample mid-bit.
module uart_baud_gen #(
    parameter int DIVISOR    = 16,
    parameter bit HALF_START = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [W-1:0] LAST = W'(DIVISOR - 1);
    localparam logic [W-1:0] LOAD = HALF_START ? W'(DIVISOR / 2) : '0;

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per tx_rdy/tx_ack handshake, LSB first,
// 1 start bit, DATA_BITS data bits, STOP_BITS stop bits, tx idles high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK     = 100000000,
    parameter int BAUDRATE  = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_rdy,
    output logic                 tx_ack,
    input  logic                 tx_enable,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int DIVISOR = calc_divisor(CLOCK, BAUDRATE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx: CLOCK/BAUDRATE must round to at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 tick;
    logic                 last_stop;
    logic                 accept;

    uart_baud_gen #(
        .DIVISOR    (DIVISOR),
        .HALF_START (1'b0)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    assign last_stop = (STOP_BITS == 1) || stop_idx;

    // Accept from IDLE, or on the final stop-bit edge for gapless back-to-back frames.
    assign accept = tx_rdy && tx_enable &&
                    ((state == IDLE) || (state == STOP && tick && last_stop));

    // NOTE: the shift register and bit index are plain flops, so they share
    // the async reset with the FSM instead of being left uninitialised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            tx_ack   <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            tx_ack <= accept;
            if (accept) begin
                shift   <= tx_data;
                bit_idx <= '0;
                tx      <= 1'b0;
                tx_busy <= 1'b1;
                state   <= START;
            end else if (tick) begin
                case (state)
                    START: begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                    DATA: begin
                        if (bit_idx == LAST_BIT) begin
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    STOP: begin
                        if (last_stop) begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Standalone UART transmitter that serializes one byte per rdy/ack handshake onto a single TX line. The bit timing is derived from the system clock via the CLOCK/BAUDRATE parameters, so no separate tx clock is needed. It sits between any byte producer, such as an echo or loopback top level, and the board TX pin. It is the transmit counterpart to the team's UART receive path.

Parameters:
- CLOCK, 100000000: system clock frequency in Hz.
- BAUDRATE, 9600: line rate in bit/s.
  - DIVISOR = CLOCK/BAUDRATE, rounded to nearest.
  - Elaboration error if DIVISOR < 2.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- tx_data, input, DATA_BITS: byte to send; must be stable while tx_rdy is high.
- tx_rdy, input, 1: producer has a valid byte on tx_data.
- tx_ack, output, 1: one-cycle pulse; the byte has been latched and consumed.
- tx_enable, input, 1: gates acceptance of new bytes only.
- tx, output, 1: serial line, registered, idles high.
- tx_busy, output, 1: high from start bit through the end of the last stop bit.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, tx_ack=0, tx_busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- States are IDLE, START, DATA, STOP.
- IDLE:
  - On an edge where tx_rdy=1 and tx_enable=1: latch tx_data into the shift register, set tx_ack=1 for exactly the next cycle, drive tx=0 and tx_busy=1, go to START.
  - Otherwise hold tx=1.
- Baud counter:
  - Counts 0..DIVISOR-1 in every non-IDLE state.
  - Each state/bit lasts exactly DIVISOR clocks, with no cumulative drift.
- START: after DIVISOR clocks, drive tx=shift[0] and go to DATA.
- DATA:
  - Bits are sent LSB first.
  - At each bit boundary, shift right and increment the bit index.
  - After DATA_BITS bits, drive tx=1 and go to STOP.
- STOP:
  - Lasts STOP_BITS*DIVISOR clocks.
  - At the end, if tx_rdy=1 and tx_enable=1: accept a new byte on the same edge (latch, tx_ack pulse, tx=0, START). Back-to-back frames have zero idle gap.
  - Otherwise go to IDLE with tx_busy=0.
- Handshake:
  - Each tx_ack consumes exactly one byte.
  - The producer must deassert tx_rdy or present new data before the current frame ends.
  - tx_rdy held high across a frame boundary means "send tx_data again".
  - tx_ack is never asserted outside an accept edge.
- tx_enable=0 mid-frame: the current frame completes normally; only the next accept is blocked.
- Frame length is (1+DATA_BITS+STOP_BITS)*DIVISOR clocks, measured from the tx falling edge to the earliest next falling edge.
- Reset mid-frame: tx returns to 1 immediately (asynchronous) and the frame is abandoned. The byte was already acked, so the producer must resend.
- tx is driven from a flop only: no combinational path from tx_rdy or tx_data to tx.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE/START/DATA/STOP);
  - the divisor rounding function calc_divisor(CLOCK, BAUDRATE), for reuse by the receiver.
- One sub-module, uart_baud_gen:
  - counter with clear input and one-cycle tick output every DIVISOR clocks;
  - same clk/rst convention;
  - also reusable by the receiver (with a half-period start option).
- All other logic (FSM, shift register, bit index) stays in uart_tx.

Test Plan:
All tests run with CLOCK=16 and BAUDRATE=1 (DIVISOR=16) unless noted.
1. Single byte: tx_data=0x55, pulse tx_rdy.
   - tx_ack high exactly 1 cycle.
   - tx sequence, each bit 16 clocks: 0, 1,0,1,0,1,0,1,0, 1.
   - tx_busy high 160 clocks, then tx=1 and idle.
2. Bit order: tx_data=0xA5.
   - Sampled mid-bit data reads 1,0,1,0,0,1,0,1 (LSB first).
   - Scoreboard reassembles 0xA5.
3. Back-to-back: tx_rdy held high; tx_data changes 0x12 -> 0x34 in the cycle after the first ack.
   - Two acks exactly 160 clocks apart.
   - Second start bit immediately follows the first stop bit (no gap).
   - Decoded bytes are 0x12, 0x34.
4. tx_enable=0 with tx_rdy=1 for 500 clocks: no tx_ack, tx stays 1.
   - Drop tx_enable during a frame of 0xFF: that frame completes with the full 160 clocks.
5. Async reset mid-frame: assert rst=0 during DATA bit 3 of 0x00.
   - tx=1, tx_busy=0, tx_ack=0 within the same cycle, without a clock edge.
   - After release, idle until a new tx_rdy.
6. STOP_BITS=2, DATA_BITS=7: send 0x7F.
   - Frame length 160 clocks, last 32 clocks high.
   - Next byte is not accepted before the second stop bit ends.
